pcie_cpl_tx: RTL and testbench

- Completion transmitter for the PCIe endpoint's 64-bit AXI4-Stream TX path, toward the core's s_axis_tx port.
- Pairs with the RX-side request decoder. It takes one decoded memory-read request plus its 32-bit read data and emits a 3DW-header completion TLP.
- Two output cases: a 1DW CplD for normal reads, or a header-only Cpl with UR status for unsupported requests.
- One completion in flight at a time; responder side of register reads.

---
 rtl/pcie_cpl_tx.sv | 162 ++++++++++++++++
 tb/tb_pcie_cpl_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cpl_tx.sv
// pcie_cpl_tx: completion transmitter for the 64-bit AXI4-Stream TX path.
// Accepts one decoded memory-read request and emits a 3DW-header completion:
// a 1DW CplD for normal reads or a header-only Cpl with UR status.
// Optional build macro: PCIE_CPL_TX_BSWAP_EN byte-reverses the CplD data DW.
module pcie_cpl_tx #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int TCQ          = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             completer_id,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_tc,
  input  logic [1:0]              req_attr,
  input  logic [15:0]             req_rid,
  input  logic [7:0]              req_tag,
  input  logic [6:0]              req_addr,
  input  logic [3:0]              req_be,
  input  logic                    req_ur,
  input  logic [31:0]             req_data,
  input  logic [5:0]              tx_buf_av,
  output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
  output logic                    s_axis_tx_tlast,
  output logic                    s_axis_tx_tvalid,
  output logic [3:0]              s_axis_tx_tuser,
  input  logic                    s_axis_tx_tready,
  output logic                    cpl_done
);

  // Only the 64-bit datapath exists; the clock-to-out delay must be sane.
  if (C_DATA_WIDTH != 64 || KEEP_WIDTH != C_DATA_WIDTH / 8 || TCQ < 0) begin : g_param_chk
    $error("pcie_cpl_tx: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t state, state_n;

  logic [2:0]  tc_p0;
  logic [1:0]  attr_p0;
  logic [15:0] rid_p0;
  logic [15:0] cid_p0;
  logic [7:0]  tag_p0;
  logic [4:0]  addr_p0;
  logic [3:0]  be_p0;
  logic        ur_p0;
  logic [31:0] data_p0;

  // Request address bits [1:0] carry no information; lower_addr comes from byte enables.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

  // Bytes covered from the first to the last enabled byte; UR always reports a full DW.
  function automatic logic [11:0] byte_count(input logic [3:0] be, input logic ur);
    logic [11:0] bc;
    if (ur) begin
      bc = 12'd4;
    end else begin
      priority casez (be)
        4'b1??1:                   bc = 12'd4;
        4'b01?1, 4'b1?10:          bc = 12'd3;
        4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
        default:                   bc = 12'd1;
      endcase
    end
    return bc;
  endfunction

  // Index of the lowest enabled byte; no enables or UR map to offset 0.
  function automatic logic [1:0] low_byte(input logic [3:0] be, input logic ur);
    logic [1:0] lo;
    if (ur || be[0]) lo = 2'd0;
    else if (be[1])  lo = 2'd1;
    else if (be[2])  lo = 2'd2;
    else if (be[3])  lo = 2'd3;
    else             lo = 2'd0;
    return lo;
  endfunction

  // Payload byte order for the CplD data DW.
  function automatic logic [31:0] payload(input logic [31:0] d);
`ifdef PCIE_CPL_TX_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  logic [2:0]  fmt;
  logic [9:0]  length;
  logic [2:0]  status;
  logic [31:0] dw0, dw1, dw2, dw3;

  assign fmt    = ur_p0 ? 3'b000 : 3'b010;
  assign length = ur_p0 ? 10'd0  : 10'd1;
  assign status = ur_p0 ? 3'b001 : 3'b000;
  assign dw0    = {fmt, 5'b01010, 1'b0, tc_p0, 4'b0000, 1'b0, 1'b0, attr_p0, 2'b00, length};
  assign dw1    = {cid_p0, status, 1'b0, byte_count(be_p0, ur_p0)};
  assign dw2    = {rid_p0, tag_p0, 1'b0, addr_p0, low_byte(be_p0, ur_p0)};
  assign dw3    = ur_p0 ? 32'd0 : payload(data_p0);

  assign s_axis_tx_tuser = 4'b0000;

  // Stage p0: capture the request on accept; held for the whole TLP so the beats stay stable.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      tc_p0   <= req_tc;
      attr_p0 <= req_attr;
      rid_p0  <= req_rid;
      cid_p0  <= completer_id;
      tag_p0  <= req_tag;
      addr_p0 <= req_addr[6:2];
      be_p0   <= req_be;
      ur_p0   <= req_ur;
      data_p0 <= req_data;
    end
  end

  // State register; reset abandons any partial TLP.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and AXIS outputs decoded from the current state.
  always_comb begin
    state_n          = state;
    req_ready        = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    cpl_done         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst && (tx_buf_av != 6'd0);
        if (req_valid && req_ready) state_n = BEAT0;
      end
      BEAT0: begin
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tkeep  = '1;
        s_axis_tx_tdata  = {dw1, dw0};
        if (s_axis_tx_tready) state_n = BEAT1;
      end
      BEAT1: begin
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tlast  = 1'b1;
        s_axis_tx_tkeep  = ur_p0 ? {{(KEEP_WIDTH-4){1'b0}}, 4'hF} : {KEEP_WIDTH{1'b1}};
        s_axis_tx_tdata  = {dw3, dw2};
        if (s_axis_tx_tready) begin
          cpl_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcie_cpl_tx.sv
// tb_pcie_cpl_tx: directed and randomized completions checked against a
// field-level reference model of the completion TLP format.
module tb_pcie_cpl_tx;

  typedef struct packed {
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [15:0] rid;
    logic [15:0] cid;
    logic [7:0]  tag;
    logic [6:0]  addr;
    logic [3:0]  be;
    logic        ur;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] completer_id;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [15:0] req_rid;
  logic [7:0]  req_tag;
  logic [6:0]  req_addr;
  logic [3:0]  req_be;
  logic        req_ur;
  logic [31:0] req_data;
  logic [5:0]  tx_buf_av;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic [3:0]  s_axis_tx_tuser;
  logic        s_axis_tx_tready;
  logic        cpl_done;

  int n_assert = 0;
  int n_fail   = 0;

  pcie_cpl_tx dut (
    .clk              (clk),
    .rst              (rst),
    .completer_id     (completer_id),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_tc           (req_tc),
    .req_attr         (req_attr),
    .req_rid          (req_rid),
    .req_tag          (req_tag),
    .req_addr         (req_addr),
    .req_be           (req_be),
    .req_ur           (req_ur),
    .req_data         (req_data),
    .tx_buf_av        (tx_buf_av),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tuser  (s_axis_tx_tuser),
    .s_axis_tx_tready (s_axis_tx_tready),
    .cpl_done         (cpl_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: build the expected beats from the completion field layout.
  function automatic void model(input req_t r, output logic [63:0] b0,
                                output logic [63:0] b1, output logic [7:0] k1);
    int first, last, bc, lo;
    logic [31:0] dw0, dw1, dw2, d;
    first = -1;
    last  = -1;
    for (int i = 0; i < 4; i++) begin
      if (r.be[i]) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    if (first < 0) begin bc = 1; lo = 0; end
    else begin bc = last - first + 1; lo = first; end
    if (r.ur) begin bc = 4; lo = 0; end
    dw0 = (r.ur ? 32'h0A00_0000 : 32'h4A00_0001) | (32'(r.tc) << 20) | (32'(r.attr) << 12);
    dw1 = (32'(r.cid) << 16) | (r.ur ? 32'h2000 : 32'h0) | 32'(bc);
    dw2 = (32'(r.rid) << 16) | (32'(r.tag) << 8) | (32'(r.addr) & 32'h7C) | 32'(lo);
`ifdef PCIE_CPL_TX_BSWAP_EN
    d = {r.data[7:0], r.data[15:8], r.data[23:16], r.data[31:24]};
`else
    d = r.data;
`endif
    if (r.ur) d = 32'd0;
    b0 = {dw1, dw0};
    b1 = {d, dw2};
    k1 = r.ur ? 8'h0F : 8'hFF;
  endfunction

  task automatic apply(input req_t r);
    req_tc = r.tc; req_attr = r.attr; req_rid = r.rid; completer_id = r.cid;
    req_tag = r.tag; req_addr = r.addr; req_be = r.be; req_ur = r.ur; req_data = r.data;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.tc = 3'($urandom); r.attr = 2'($urandom); r.rid = 16'($urandom);
    r.cid = 16'($urandom); r.tag = 8'($urandom); r.addr = 7'($urandom);
    r.be = 4'($urandom); r.ur = ($urandom_range(0, 3) == 0); r.data = $urandom;
    return r;
  endfunction

  task automatic check_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                            input logic l, input logic done);
    check({tag, ".tvalid"}, 64'(s_axis_tx_tvalid), 64'd1);
    check({tag, ".tdata"},  s_axis_tx_tdata, d);
    check({tag, ".tkeep"},  64'(s_axis_tx_tkeep), 64'(k));
    check({tag, ".tlast"},  64'(s_axis_tx_tlast), 64'(l));
    check({tag, ".cpl_done"}, 64'(cpl_done), 64'(done));
    check({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    check({tag, ".tuser"}, 64'(s_axis_tx_tuser), 64'd0);
  endtask

  // One full completion; starts and ends just after a rising edge.
  task automatic run_cpl(input string tag, input req_t r, input int st0, input int st1,
                         input bit hold_valid, input bit drop_buf);
    logic [63:0] b0, b1;
    logic [7:0]  k1;
    model(r, b0, b1, k1);
    apply(r);
    req_valid = 1'b1;
    if (tx_buf_av == 6'd0) tx_buf_av = 6'd1;
    @(negedge clk);
    check({tag, ".acc_ready"}, 64'(req_ready), 64'd1);
    check({tag, ".acc_tvalid"}, 64'(s_axis_tx_tvalid), 64'd0);
    @(posedge clk); #1;
    req_valid = hold_valid;
    apply(rand_req());
    if (drop_buf) tx_buf_av = 6'd0;
    for (int i = 0; i < st0; i++) begin
      s_axis_tx_tready = 1'b0;
      @(negedge clk); check_beat({tag, ".b0stall"}, b0, 8'hFF, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    s_axis_tx_tready = 1'b1;
    @(negedge clk); check_beat({tag, ".b0"}, b0, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < st1; i++) begin
      s_axis_tx_tready = 1'b0;
      @(negedge clk); check_beat({tag, ".b1stall"}, b1, k1, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    s_axis_tx_tready = 1'b1;
    @(negedge clk); check_beat({tag, ".b1"}, b1, k1, 1'b1, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    s_axis_tx_tready = 1'($urandom);
    tx_buf_av = 6'($urandom_range(1, 63));
    @(negedge clk);
    check({tag, ".end_tvalid"}, 64'(s_axis_tx_tvalid), 64'd0);
    check({tag, ".end_done"}, 64'(cpl_done), 64'd0);
    check({tag, ".end_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    req_t r;
    logic [63:0] b0, b1;
    logic [7:0]  k1;
    rst = 1'b1; req_valid = 1'b0; s_axis_tx_tready = 1'b1; tx_buf_av = 6'd8;
    apply('0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst.req_ready", 64'(req_ready), 64'd0);
    check("rst.tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("rst.tdata", s_axis_tx_tdata, 64'd0);
    check("rst.tkeep", 64'(s_axis_tx_tkeep), 64'd0);
    check("rst.tlast", 64'(s_axis_tx_tlast), 64'd0);
    check("rst.tuser", 64'(s_axis_tx_tuser), 64'd0);
    check("rst.cpl_done", 64'(cpl_done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle.req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    r = '{tc:3'd0, attr:2'd0, rid:16'h0100, cid:16'h0200, tag:8'h1A, addr:7'h14,
          be:4'b1111, ur:1'b0, data:32'hDEADBEEF};
    model(r, b0, b1, k1);
    check("plan.beat1_const", b1, 64'hDEADBEEF_01001A14);
    run_cpl("cpld", r, 0, 0, 1'b0, 1'b0);

    r = '{tc:3'd2, attr:2'd1, rid:16'h0300, cid:16'h0200, tag:8'h05, addr:7'h20,
          be:4'b0001, ur:1'b1, data:32'hCAFEF00D};
    run_cpl("ur", r, 0, 0, 1'b0, 1'b0);

    r = '{tc:3'd0, attr:2'd0, rid:16'h0100, cid:16'h0200, tag:8'h10, addr:7'h10,
          be:4'b0100, ur:1'b0, data:32'h11223344};
    run_cpl("be0100", r, 0, 0, 1'b0, 1'b0);
    r.be = 4'b0110; r.tag = 8'h11; run_cpl("be0110", r, 0, 0, 1'b0, 1'b0);
    r.be = 4'b1110; r.tag = 8'h12; run_cpl("be1110", r, 0, 0, 1'b0, 1'b0);
    r.be = 4'b0000; r.tag = 8'h13; run_cpl("be0000", r, 0, 0, 1'b0, 1'b0);

    r = rand_req(); r.ur = 1'b0;
    run_cpl("bp", r, 5, 3, 1'b1, 1'b0);

    tx_buf_av = 6'd0;
    r = rand_req();
    apply(r);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gate.req_ready", 64'(req_ready), 64'd0);
      check("gate.tvalid", 64'(s_axis_tx_tvalid), 64'd0);
      @(posedge clk); #1;
    end
    tx_buf_av = 6'd1;
    run_cpl("gate", r, 0, 1, 1'b0, 1'b1);

    r = rand_req();
    model(r, b0, b1, k1);
    apply(r);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    s_axis_tx_tready = 1'b1;
    @(negedge clk); check_beat("rstb1.b0", b0, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    s_axis_tx_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstb1.in_beat1", 64'(s_axis_tx_tvalid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstb1.tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("rstb1.idle_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    for (int n = 0; n < 24; n++) begin
      run_cpl("rand", rand_req(), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
